line_clear_controller: RTL and testbench

LINE_CLEAR_CONTROLLER -- requirements
Module: line_clear_controller

---
 rtl/line_clear_controller.sv | 123 ++++++++++++
 tb/tb_line_clear_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/line_clear_controller.sv
// Line-clear engine: scans a locked playfield bottom-up, collapses full rows one
// at a time, then publishes the result to the display only during vertical blanking.
module line_clear_controller #(
  parameter int ROWS = 20,
  parameter int COLS = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ROWS*COLS-1:0]   grid_in,
  input  logic                   vblank,
  output logic [ROWS*COLS-1:0]   grid_out,
  output logic [4:0]             lines_cleared,
  output logic                   busy,
  output logic                   done
);

  localparam int GW = ROWS * COLS;

  // Handshake: start is sampled only while idle (busy=0, which includes the
  // cycle done is high); starts seen while busy are dropped, never queued.
  // done pulses for one cycle in the same cycle grid_out/lines_cleared update.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    SHIFT  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t          state_q, state_n;
  logic [GW-1:0]   work_q, work_n, shifted;
  logic [4:0]      row_idx_q, row_idx_n;
  logic [4:0]      cnt_q, cnt_n;
  logic [COLS-1:0] cur_row;
  logic            row_full;
  logic            commit;

  always_comb begin
    cur_row = '0;
    for (int k = 0; k < ROWS; k++) begin
      if (row_idx_q == 5'(k)) cur_row = work_q[k*COLS +: COLS];
    end
  end

  assign row_full = &cur_row;

  // Everything at or above row_idx drops by one row; row 0 refills empty.
  always_comb begin
    shifted = work_q;
    for (int k = 0; k < ROWS; k++) begin
      if (k == 0) begin
        shifted[k*COLS +: COLS] = '0;
      end else if (5'(k) <= row_idx_q) begin
        shifted[k*COLS +: COLS] = work_q[(k-1)*COLS +: COLS];
      end
    end
  end

  always_comb begin
    state_n   = state_q;
    work_n    = work_q;
    row_idx_n = row_idx_q;
    cnt_n     = cnt_q;
    commit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_n    = grid_in;
          row_idx_n = 5'(ROWS - 1);
          cnt_n     = 5'd0;
          state_n   = SCAN;
        end
      end
      SCAN: begin
        if (row_full) begin
          state_n = SHIFT;
        end else if (row_idx_q == 5'd0) begin
          state_n = COMMIT;
        end else begin
          row_idx_n = row_idx_q - 5'd1;
        end
      end
      SHIFT: begin
        // Same row_idx is re-checked next, since a full row may have dropped in.
        work_n  = shifted;
        cnt_n   = cnt_q + 5'd1;
        state_n = SCAN;
      end
      COMMIT: begin
        if (vblank) begin
          commit  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      work_q        <= '0;
      row_idx_q     <= '0;
      cnt_q         <= '0;
      grid_out      <= '0;
      lines_cleared <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q   <= state_n;
      work_q    <= work_n;
      row_idx_q <= row_idx_n;
      cnt_q     <= cnt_n;
      busy      <= (state_n != IDLE);
      done      <= commit;
      if (commit) begin
        grid_out      <= work_q;
        lines_cleared <= cnt_q;
      end
    end
  end

endmodule

// File: tb/tb_line_clear_controller.sv
// Directed and randomized checks of line_clear_controller against a row-list
// reference model (full rows removed, survivors settle to the bottom).
module tb_line_clear_controller;

  localparam int ROWS = 20;
  localparam int COLS = 12;
  localparam int GW   = ROWS * COLS;

  logic          clk;
  logic          rst;
  logic          start;
  logic [GW-1:0] grid_in;
  logic          vblank;
  logic [GW-1:0] grid_out;
  logic [4:0]    lines_cleared;
  logic          busy;
  logic          done;

  int            n_checks;
  int            n_errors;
  logic [GW-1:0] last_exp;

  line_clear_controller #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .grid_in       (grid_in),
    .vblank        (vblank),
    .grid_out      (grid_out),
    .lines_cleared (lines_cleared),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [GW-1:0] obs, input logic [GW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: keep non-full rows in bottom-up order, restack them from row 19 up.
  task automatic model(input logic [GW-1:0] g, output logic [GW-1:0] res, output int k);
    logic [COLS-1:0] kept[$];
    logic [COLS-1:0] row;
    k = 0;
    res = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      row = g[r*COLS +: COLS];
      if (row == {COLS{1'b1}}) k++;
      else kept.push_back(row);
    end
    for (int i = 0; i < kept.size(); i++) res[(ROWS-1-i)*COLS +: COLS] = kept[i];
  endtask

  function automatic logic [GW-1:0] rand_grid(input int full_pct);
    logic [GW-1:0] g;
    int sel;
    g = '0;
    for (int r = 0; r < ROWS; r++) begin
      sel = $urandom_range(0, 99);
      if (sel < full_pct) g[r*COLS +: COLS] = {COLS{1'b1}};
      else if (sel < full_pct + 15) g[r*COLS +: COLS] = '0;
      else g[r*COLS +: COLS] = COLS'($urandom);
    end
    return g;
  endfunction

  function automatic logic [GW-1:0] set_row(input logic [GW-1:0] g, input int r, input logic [COLS-1:0] v);
    logic [GW-1:0] t;
    t = g;
    t[r*COLS +: COLS] = v;
    return t;
  endfunction

  // Called at a negedge with vblank high; returns at the negedge where done is seen.
  task automatic run_op(input logic [GW-1:0] g, input string tag);
    logic [GW-1:0] eg;
    int ek, edges, busy_cnt;
    bit seen;
    model(g, eg, ek);
    start   = 1'b1;
    grid_in = g;
    @(negedge clk);
    start   = 1'b0;
    grid_in = rand_grid(50);
    edges = 0;
    busy_cnt = 0;
    seen = 1'b0;
    while (!seen && edges < 200) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) busy_cnt++;
        @(negedge clk);
        edges++;
      end
    end
    chk({tag, ".done_seen"}, GW'(seen), GW'(1));
    chk({tag, ".latency"}, GW'(edges), GW'(21 + 2 * ek));
    chk({tag, ".busy_cycles"}, GW'(busy_cnt), GW'(21 + 2 * ek));
    chk({tag, ".busy_at_done"}, GW'(busy), GW'(0));
    chk({tag, ".lines"}, GW'(lines_cleared), GW'(ek));
    chk({tag, ".grid"}, grid_out, eg);
    last_exp = eg;
  endtask

  initial begin
    logic [GW-1:0] g, e1;
    int k1;
    bit seen_done, changed;

    n_checks = 0;
    n_errors = 0;
    last_exp = '0;
    rst = 1'b0;
    start = 1'b0;
    vblank = 1'b1;
    grid_in = '0;

    #3;
    chk("reset.grid_out", grid_out, '0);
    chk("reset.lines", GW'(lines_cleared), '0);
    chk("reset.busy", GW'(busy), '0);
    chk("reset.done", GW'(done), '0);
    @(negedge clk);
    rst = 1'b1;

    // Empty grid: first start at the first edge after reset release.
    run_op('0, "empty");

    // Row 19 full, row 18 = 001; started in the done cycle of the previous op.
    g = set_row(set_row('0, 19, 12'hFFF), 18, 12'h001);
    run_op(g, "one_line");
    chk("one_line.row19", GW'(grid_out[19*COLS +: COLS]), GW'(12'h001));

    g = set_row(set_row(set_row(set_row('0, 19, 12'hFFF), 18, 12'h0F0), 17, 12'hFFF), 16, 12'h003);
    run_op(g, "two_lines");
    chk("two_lines.row19", GW'(grid_out[19*COLS +: COLS]), GW'(12'h0F0));
    chk("two_lines.row18", GW'(grid_out[18*COLS +: COLS]), GW'(12'h003));

    run_op('1, "all_full");
    chk("all_full.lines20", GW'(lines_cleared), GW'(5'b10100));

    for (int i = 0; i < 24; i++) begin
      run_op(rand_grid($urandom_range(0, 60)), $sformatf("rand%0d", i));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end

    // COMMIT held off by vblank; a start while busy must be dropped.
    g = set_row(set_row('0, 19, 12'hFFF), 18, 12'h5A5);
    model(g, e1, k1);
    @(negedge clk);
    vblank = 1'b0;
    start = 1'b1;
    grid_in = g;
    @(negedge clk);
    start = 1'b0;
    grid_in = '1;
    seen_done = 1'b0;
    changed = 1'b0;
    for (int i = 0; i < 21 + 2 * k1 + 100; i++) begin
      if (done) seen_done = 1'b1;
      if (grid_out !== last_exp) changed = 1'b1;
      start = (i == 30);
      @(negedge clk);
    end
    chk("vblank_hold.busy", GW'(busy), GW'(1));
    chk("vblank_hold.no_done", GW'(seen_done), GW'(0));
    chk("vblank_hold.grid_stable", GW'(changed), GW'(0));
    vblank = 1'b1;
    @(negedge clk);
    chk("vblank_hold.done", GW'(done), GW'(1));
    chk("vblank_hold.lines", GW'(lines_cleared), GW'(k1));
    chk("vblank_hold.grid", grid_out, e1);
    last_exp = e1;
    @(negedge clk);
    chk("vblank_hold.done_pulse", GW'(done), GW'(0));
    repeat (2) @(negedge clk);
    chk("vblank_hold.no_queue", GW'(busy), GW'(0));

    // Reset while in SHIFT: outputs clear without a clock edge.
    start = 1'b1;
    grid_in = set_row('0, 19, 12'hFFF);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_shift.grid_out", grid_out, '0);
    chk("rst_shift.lines", GW'(lines_cleared), '0);
    chk("rst_shift.busy", GW'(busy), '0);
    chk("rst_shift.done", GW'(done), '0);
    @(negedge clk);
    rst = 1'b1;
    run_op('0, "after_rst");

    // Reset while COMMIT waits on vblank: no commit, no done afterwards.
    @(negedge clk);
    vblank = 1'b0;
    start = 1'b1;
    grid_in = set_row(rand_grid(30), 19, 12'hFFF);
    @(negedge clk);
    start = 1'b0;
    repeat (70) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_commit.busy", GW'(busy), '0);
    @(negedge clk);
    rst = 1'b1;
    vblank = 1'b1;
    seen_done = 1'b0;
    changed = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done) seen_done = 1'b1;
      if (grid_out !== '0) changed = 1'b1;
      @(negedge clk);
    end
    chk("rst_commit.no_done", GW'(seen_done), GW'(0));
    chk("rst_commit.grid_zero", GW'(changed), GW'(0));
    run_op(rand_grid(40), "recover");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
